rx_window_controller: RTL and testbench

//  Sequences the preamble_detector for one tag reply per reader command: holds the detector in reset while idle.

---
 rtl/rx_window_controller.sv | 172 +++++++++++++++++
 tb/tb_rx_window_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_window_controller.sv
// Receive-window sequencer for the preamble detector: hold-off, listen, forward rx_len bits, flush.
// Optional `RX_BIT_TIMEOUT_EN aborts a reply whose inter-bit gap reaches BIT_GAP_MAX cycles.
module rx_window_controller #(
   parameter int BANK_WIDTH   = 2,
   parameter int LEN_WIDTH    = 10,
   parameter int TIMER_WIDTH  = 16,
   parameter int T1_MIN       = 64,
   parameter int T1_MAX       = 4096,
   parameter int FLUSH_CYCLES = 4,
   parameter int BIT_GAP_MAX  = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tx_done,
   input  logic [LEN_WIDTH-1:0]  rx_len,
   output logic                  det_rst,
   output logic                  det_en,
   input  logic                  det_preamble,
   input  logic [BANK_WIDTH-1:0] det_bank,
   input  logic                  det_out_dat,
   input  logic                  det_out_vld,
   output logic                  rx_dat,
   output logic                  rx_vld,
   output logic                  rx_last,
   output logic [BANK_WIDTH-1:0] rx_bank,
   output logic                  rx_done,
   output logic                  rx_timeout,
   output logic                  busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_HOLDOFF, S_LISTEN, S_RECEIVE, S_FLUSH
   } state_t;

   if (T1_MIN < 1 || T1_MAX <= T1_MIN || FLUSH_CYCLES < 3 || BIT_GAP_MAX < 1) begin : g_param_check
      $error("rx_window_controller: illegal parameter set");
   end

   state_t                 state_q, state_d;
   logic [TIMER_WIDTH-1:0] timer_q, timer_d;
   logic [LEN_WIDTH-1:0]   len_q, len_d;
   logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
   logic [LEN_WIDTH-1:0]   cnt_inc;
   logic                   bit_fire, done_fire, timeout_fire, bank_load;

   logic                  det_rst_q, det_rst_d, det_en_q, det_en_d;
   logic                  rx_dat_q, rx_dat_d, rx_vld_q, rx_vld_d, rx_last_q, rx_last_d;
   logic [BANK_WIDTH-1:0] rx_bank_q, rx_bank_d;
   logic                  rx_done_q, rx_done_d, rx_timeout_q, rx_timeout_d, busy_q, busy_d;

   assign cnt_inc = cnt_q + LEN_WIDTH'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         timer_q      <= '0;
         len_q        <= '0;
         cnt_q        <= '0;
         det_rst_q    <= 1'b1;
         det_en_q     <= 1'b0;
         rx_dat_q     <= 1'b0;
         rx_vld_q     <= 1'b0;
         rx_last_q    <= 1'b0;
         rx_bank_q    <= '0;
         rx_done_q    <= 1'b0;
         rx_timeout_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         len_q        <= len_d;
         cnt_q        <= cnt_d;
         det_rst_q    <= det_rst_d;
         det_en_q     <= det_en_d;
         rx_dat_q     <= rx_dat_d;
         rx_vld_q     <= rx_vld_d;
         rx_last_q    <= rx_last_d;
         rx_bank_q    <= rx_bank_d;
         rx_done_q    <= rx_done_d;
         rx_timeout_q <= rx_timeout_d;
         busy_q       <= busy_d;
      end
   end

   // One timer serves three roles: tx_done-relative window, inter-bit gap, flush length.
   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      len_d        = len_q;
      cnt_d        = cnt_q;
      bit_fire     = 1'b0;
      done_fire    = 1'b0;
      timeout_fire = 1'b0;
      bank_load    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (tx_done && rx_len != '0) begin
               state_d = S_HOLDOFF;
               len_d   = rx_len;
               timer_d = '0;
            end
         end
         S_HOLDOFF: begin
            timer_d = timer_q + TIMER_WIDTH'(1);
            if (timer_q == TIMER_WIDTH'(T1_MIN - 1)) state_d = S_LISTEN;
         end
         S_LISTEN: begin
            timer_d = timer_q + TIMER_WIDTH'(1);
            if (det_preamble) begin
               state_d   = S_RECEIVE;
               bank_load = 1'b1;
               cnt_d     = '0;
               timer_d   = '0;
            end else if (timer_q == TIMER_WIDTH'(T1_MAX - 1)) begin
               state_d      = S_FLUSH;
               timeout_fire = 1'b1;
               timer_d      = '0;
            end
         end
         S_RECEIVE: begin
            if (det_out_vld) begin
               bit_fire = 1'b1;
               cnt_d    = cnt_inc;
               timer_d  = '0;
               if (cnt_inc == len_q) begin
                  done_fire = 1'b1;
                  state_d   = S_FLUSH;
               end
            end
`ifdef RX_BIT_TIMEOUT_EN
            else begin
               timer_d = timer_q + TIMER_WIDTH'(1);
               if (timer_q == TIMER_WIDTH'(BIT_GAP_MAX - 1)) begin
                  state_d      = S_FLUSH;
                  timeout_fire = 1'b1;
                  timer_d      = '0;
               end
            end
`else
`endif
         end
         S_FLUSH: begin
            timer_d = timer_q + TIMER_WIDTH'(1);
            if (timer_q == TIMER_WIDTH'(FLUSH_CYCLES - 1)) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      det_en_d     = (state_d == S_LISTEN) || (state_d == S_RECEIVE);
      det_rst_d    = !det_en_d;
      busy_d       = (state_d != S_IDLE);
      rx_vld_d     = bit_fire;
      rx_dat_d     = bit_fire & det_out_dat;
      rx_last_d    = done_fire;
      rx_done_d    = done_fire;
      rx_timeout_d = timeout_fire;
      rx_bank_d    = bank_load ? det_bank : rx_bank_q;
   end

   assign det_rst    = det_rst_q;
   assign det_en     = det_en_q;
   assign rx_dat     = rx_dat_q;
   assign rx_vld     = rx_vld_q;
   assign rx_last    = rx_last_q;
   assign rx_bank    = rx_bank_q;
   assign rx_done    = rx_done_q;
   assign rx_timeout = rx_timeout_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_rx_window_controller.sv
// Directed bench for rx_window_controller; output events are scoreboarded through exp_q.
module tb_rx_window_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tx_done = 1'b0;
   logic [9:0] rx_len = '0;
   logic       det_rst, det_en;
   logic       det_preamble = 1'b0;
   logic [1:0] det_bank = '0;
   logic       det_out_dat = 1'b0;
   logic       det_out_vld = 1'b0;
   logic       rx_dat, rx_vld, rx_last, rx_done, rx_timeout, busy;
   logic [1:0] rx_bank;

   // Event word: {vld, dat, last, done, timeout, bank[1:0]}
   logic [6:0] exp_q[$];
   logic [1:0] exp_bank = '0;
   int         n_checks = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         f0;

   rx_window_controller #(
      .BANK_WIDTH(2), .LEN_WIDTH(10), .TIMER_WIDTH(16),
      .T1_MIN(8), .T1_MAX(32), .FLUSH_CYCLES(4), .BIT_GAP_MAX(20)
   ) dut (
      .clk(clk), .rst(rst), .tx_done(tx_done), .rx_len(rx_len),
      .det_rst(det_rst), .det_en(det_en), .det_preamble(det_preamble),
      .det_bank(det_bank), .det_out_dat(det_out_dat), .det_out_vld(det_out_vld),
      .rx_dat(rx_dat), .rx_vld(rx_vld), .rx_last(rx_last), .rx_bank(rx_bank),
      .rx_done(rx_done), .rx_timeout(rx_timeout), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic go_to(input int c);
      while (cyc < c) step();
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_det_rst"}, det_rst, 1);
      check({tag, "_det_en"}, det_en, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_rx_out"}, {rx_vld, rx_dat, rx_last, rx_done, rx_timeout}, 0);
      check({tag, "_rx_bank"}, rx_bank, 0);
   endtask

   // tx_done is sampled by the edge inside this task; cycle 0 begins right after it.
   task automatic send_cmd(input logic [9:0] len);
      tx_done = 1'b1;
      rx_len  = len;
      step();
      tx_done = 1'b0;
      rx_len  = 10'h3ff;
      cyc     = 0;
   endtask

   task automatic preamble(input logic [1:0] bank);
      det_preamble = 1'b1;
      det_bank     = bank;
      step();
      det_preamble = 1'b0;
      det_bank     = ~bank;
   endtask

   task automatic send_bits(input logic [15:0] pat, input int first, input int count, input int len);
      for (int i = first; i < first + count; i++) begin
         det_out_vld = 1'b1;
         det_out_dat = pat[i];
         exp_q.push_back({1'b1, pat[i], (i == len - 1), (i == len - 1), 1'b0, exp_bank});
         step();
      end
      det_out_vld = 1'b0;
      det_out_dat = 1'b0;
   endtask

   always @(negedge clk) begin
      logic [6:0] act;
      logic [6:0] e;
      if (rx_vld || rx_done || rx_timeout) begin
         act = {rx_vld, rx_dat, rx_last, rx_done, rx_timeout, rx_bank};
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output: got %b expected no event", act);
         end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
               n_fail++;
               $display("FAIL output_event: got %b expected %b", act, e);
            end
         end
      end
   end

   initial begin
      repeat (3) step();
      check_reset_values("reset");
      rst = 1'b0;
      step();

      // tx_done with rx_len == 0 is ignored
      send_cmd(10'd0);
      go_to(3);
      check("zero_len_busy", busy, 0);

      // 1. Normal reply of 16 bits, tx_done while busy ignored
      send_cmd(10'd16);
      go_to(7);
      check("t1_det_en_c7", det_en, 0);
      check("t1_busy_c7", busy, 1);
      go_to(8);
      check("t1_det_en_c8", det_en, 1);
      check("t1_det_rst_c8", det_rst, 0);
      go_to(12);
      exp_bank = 2'd2;
      preamble(2'd2);
      send_bits(16'hA5C3, 0, 7, 16);
      tx_done = 1'b1;
      rx_len  = 10'd3;
      send_bits(16'hA5C3, 7, 1, 16);
      tx_done = 1'b0;
      send_bits(16'hA5C3, 8, 8, 16);
      check("t1_done_cycle", cyc, 29);
      check("t1_rx_done", rx_done, 1);
      check("t1_det_rst_flush", det_rst, 1);
      f0 = cyc;
      det_out_vld = 1'b1;
      det_out_dat = 1'b1;
      step();
      step();
      step();
      det_out_vld = 1'b0;
      det_out_dat = 1'b0;
      check("t1_busy_flush_end", busy, 1);
      go_to(f0 + 4);
      check("t1_busy_idle", busy, 0);
      go_to(f0 + 10);
      check("t1_tx_done_ignored", busy, 0);

      // 2. No reply: timeout at cycle 32
      send_cmd(10'd5);
      go_to(31);
      check("t2_timeout_c31", rx_timeout, 0);
      exp_q.push_back({5'b00001, exp_bank});
      go_to(32);
      check("t2_timeout_c32", rx_timeout, 1);
      check("t2_det_rst_c32", det_rst, 1);
      go_to(33);
      check("t2_timeout_c33", rx_timeout, 0);
      go_to(35);
      check("t2_busy_c35", busy, 1);
      go_to(36);
      check("t2_busy_c36", busy, 0);

      // 3. Preamble in HOLDOFF ignored; later preamble latches bank
      send_cmd(10'd3);
      go_to(3);
      check("t3_det_rst_c3", det_rst, 1);
      preamble(2'd1);
      check("t3_holdoff_det_en", det_en, 0);
      go_to(9);
      check("t3_bank_held", rx_bank, 2);
      go_to(10);
      exp_bank = 2'd3;
      preamble(2'd3);
      check("t3_bank_latched", rx_bank, 3);
      send_bits(16'h0005, 0, 3, 3);
      go_to(cyc + 5);
      check("t3_idle", busy, 0);

      // 4. Preamble coincident with T1_MAX expiry wins
      send_cmd(10'd2);
      go_to(31);
      exp_bank = 2'd1;
      preamble(2'd1);
      check("t4_no_timeout", rx_timeout, 0);
      check("t4_det_en", det_en, 1);
      send_bits(16'h0002, 0, 2, 2);
      go_to(cyc + 5);
      check("t4_idle", busy, 0);

      // 5. rst mid-RECEIVE after 5 bits
      send_cmd(10'd16);
      go_to(12);
      exp_bank = 2'd2;
      preamble(2'd2);
      send_bits(16'h0016, 0, 5, 16);
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_bank = 2'd0;
      check_reset_values("t5_after_rst");
      go_to(cyc + 3);
      check("t5_busy_stays_low", busy, 0);

      // 6. Inter-bit gap of 20 idle cycles
      send_cmd(10'd10);
      go_to(12);
      exp_bank = 2'd2;
      preamble(2'd2);
      send_bits(16'h0006, 0, 4, 10);
      f0 = cyc;
`ifdef RX_BIT_TIMEOUT_EN
      exp_q.push_back({5'b00001, exp_bank});
      go_to(f0 + 19);
      check("t6_timeout_early", rx_timeout, 0);
      go_to(f0 + 20);
      check("t6_timeout", rx_timeout, 1);
      check("t6_no_done", rx_done, 0);
      go_to(f0 + 24);
      check("t6_idle", busy, 0);
`else
      go_to(f0 + 25);
      check("t6_still_receive", det_en, 1);
      check("t6_busy", busy, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t6_rst_busy", busy, 0);
`endif

      step();
      step();
      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
